uart_cmd_decoder: RTL and testbench

//  Byte-level command decoder for the received-byte stream (rx_data/rx_data_rdy) of the lab3 clock.

---
 rtl/uart_cmd_decoder_if.sv | 25 ++
 rtl/uart_cmd_decoder.sv | 130 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - byte-in / load-out bundle between UART receiver and clock datapath
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       ld_time;
    logic       ld_alarm;
    logic [3:0] mtens;
    logic [3:0] mones;
    logic [3:0] stens;
    logic [3:0] sones;
    logic       cmd_err;
    logic       busy;

    // Byte source side (UART receiver / bench)
    modport master (
        output rx_data, rx_data_rdy,
        input  ld_time, ld_alarm, mtens, mones, stens, sones, cmd_err, busy
    );

    // Decoder side
    modport slave (
        input  rx_data, rx_data_rdy,
        output ld_time, ld_alarm, mtens, mones, stens, sones, cmd_err, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - parses l/L + 4 BCD digits + CR into time/alarm load strobes
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYC = 12_000_000,
    parameter int unsigned TMR_W       = 24
) (
    input  logic             clk12m,
    input  logic             rst_n,
    uart_cmd_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIG  = 2'd1,
        S_WCR  = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       CH_LO    = 8'h6C;
    localparam logic [7:0]       CH_UP    = 8'h4C;
    localparam logic [7:0]       CH_CR    = 8'h0D;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic             cmd_q;
    logic [3:0][3:0]  shadow_q;
    logic [TMR_W-1:0] tmr_q;
    logic [3:0][3:0]  digits_q;
    logic             ld_time_q;
    logic             ld_alarm_q;
    logic             cmd_err_q;
    logic             busy_q;

    logic             is_cmd_d;
    logic             is_alarm_d;
    logic             is_digit_d;
    logic [3:0]       digit_d;
    logic             range_ok_d;
    logic [TMR_W-1:0] tmr_inc_d;

    // Byte classification; tens positions (even index) only accept 0-5
    always_comb begin
        is_cmd_d   = (bus.rx_data == CH_LO) || (bus.rx_data == CH_UP);
        is_alarm_d = (bus.rx_data == CH_UP);
        is_digit_d = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        digit_d    = bus.rx_data[3:0];
        range_ok_d = idx_q[0] || (digit_d <= 4'd5);
        tmr_inc_d  = tmr_q + 1'b1;
    end

    // Command FSM with registered strobes, digit outputs and inter-byte timer
    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cmd_q      <= 1'b0;
            shadow_q   <= '0;
            tmr_q      <= '0;
            digits_q   <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tmr_q <= '0;
                    if (bus.rx_data_rdy && is_cmd_d) begin
                        state_q <= S_DIG;
                        idx_q   <= 2'd0;
                        cmd_q   <= is_alarm_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_DIG, S_WCR: begin
                    if (bus.rx_data_rdy) begin
                        tmr_q <= '0;
                        if (is_cmd_d) begin
                            // A fresh command letter aborts the old one and starts over
                            cmd_err_q <= 1'b1;
                            state_q   <= S_DIG;
                            idx_q     <= 2'd0;
                            cmd_q     <= is_alarm_d;
                            busy_q    <= 1'b1;
                        end else if ((state_q == S_DIG) && is_digit_d && range_ok_d) begin
                            shadow_q[idx_q] <= digit_d;
                            if (idx_q == 2'd3) begin
                                state_q <= S_WCR;
                            end else begin
                                idx_q <= idx_q + 2'd1;
                            end
                        end else if ((state_q == S_WCR) && (bus.rx_data == CH_CR)) begin
                            digits_q   <= shadow_q;
                            ld_time_q  <= ~cmd_q;
                            ld_alarm_q <= cmd_q;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            cmd_err_q <= 1'b1;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end else if (tmr_q == TMR_LAST) begin
                        cmd_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        tmr_q     <= '0;
                    end else begin
                        tmr_q <= tmr_inc_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ld_time  = ld_time_q;
    assign bus.ld_alarm = ld_alarm_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.busy     = busy_q;
    assign bus.mtens    = digits_q[0];
    assign bus.mones    = digits_q[1];
    assign bus.stens    = digits_q[2];
    assign bus.sones    = digits_q[3];
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - randomized and directed checks of uart_cmd_decoder against a byte-queue model
module tb_uart_cmd_decoder;
    localparam int T = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.TIMEOUT_CYC(T), .TMR_W(24)) dut (
        .clk12m (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the pending command kept in a queue
    logic [7:0] mq[$];
    logic [7:0] mb;
    int         silent = 0;
    logic       e_lt = 0, e_la = 0, e_err = 0, e_busy = 0;
    logic [3:0] e_d [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            silent = 0;
            e_lt = 0; e_la = 0; e_err = 0; e_busy = 0;
            for (int i = 0; i < 4; i++) e_d[i] = 4'd0;
        end else begin
            e_lt = 0; e_la = 0; e_err = 0;
            if (bus.rx_data_rdy) begin
                silent = 0;
                mb = bus.rx_data;
                if (mq.size() == 0) begin
                    if (mb == 8'h6C || mb == 8'h4C) mq.push_back(mb);
                end else if (mb == 8'h6C || mb == 8'h4C) begin
                    e_err = 1;
                    mq.delete();
                    mq.push_back(mb);
                end else if (mq.size() == 5) begin
                    if (mb == 8'h0D) begin
                        for (int i = 0; i < 4; i++) e_d[i] = 4'(mq[i+1] - 8'h30);
                        if (mq[0] == 8'h6C) e_lt = 1; else e_la = 1;
                    end else begin
                        e_err = 1;
                    end
                    mq.delete();
                end else if (mb >= 8'h30 && mb <= 8'h39 && ((mq.size() % 2) == 0 || mb <= 8'h35)) begin
                    mq.push_back(mb);
                end else begin
                    e_err = 1;
                    mq.delete();
                end
            end else if (mq.size() != 0) begin
                silent++;
                if (silent == T) begin
                    e_err = 1;
                    mq.delete();
                    silent = 0;
                end
            end
            e_busy = (mq.size() != 0);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("ld_time",  32'(bus.ld_time),  32'(e_lt));
        chk("ld_alarm", 32'(bus.ld_alarm), 32'(e_la));
        chk("cmd_err",  32'(bus.cmd_err),  32'(e_err));
        chk("busy",     32'(bus.busy),     32'(e_busy));
        chk("digits",   {16'd0, bus.mtens, bus.mones, bus.stens, bus.sones},
                        {16'd0, e_d[0], e_d[1], e_d[2], e_d[3]});
    end

    task automatic put(input logic [7:0] b);
        bus.rx_data     = b;
        bus.rx_data_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_data_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_gap(input logic [7:0] b);
        int g;
        put(b);
        g = $urandom_range(0, 99);
        if (g < 50)      g = 0;
        else if (g < 92) g = $urandom_range(1, 5);
        else             g = $urandom_range(T - 3, T + 3);
        idle(g);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55)      return 8'(8'h30 + $urandom_range(0, 9));
        else if (r < 65) return 8'h6C;
        else if (r < 75) return 8'h4C;
        else if (r < 88) return 8'h0D;
        else             return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [15:0] digs();
        return {bus.mtens, bus.mones, bus.stens, bus.sones};
    endfunction

    initial begin
        bus.rx_data     = 8'h00;
        bus.rx_data_rdy = 1'b0;
        idle(3);
        chk("reset_busy",   32'(bus.busy), 32'd0);
        chk("reset_digits", 32'(digs()), 32'h0000);
        rst_n = 1'b1;
        idle(2);

        // Load time 59:55
        put(8'h6C); put(8'h35); put(8'h39); put(8'h35); put(8'h35); put(8'h0D);
        chk("t1_ld_time",  32'(bus.ld_time), 32'd1);
        chk("t1_ld_alarm", 32'(bus.ld_alarm), 32'd0);
        chk("t1_digits",   32'(digs()), 32'h5955);
        chk("t1_busy",     32'(bus.busy), 32'd0);
        idle(5);

        // Load alarm 03:24
        put(8'h4C); put(8'h30); put(8'h33); put(8'h32); put(8'h34); put(8'h0D);
        chk("t2_ld_alarm", 32'(bus.ld_alarm), 32'd1);
        chk("t2_ld_time",  32'(bus.ld_time), 32'd0);
        chk("t2_digits",   32'(digs()), 32'h0324);
        idle(3);

        // Minutes tens out of range
        put(8'h6C); put(8'h36);
        chk("t3_err", 32'(bus.cmd_err), 32'd1);
        put(8'h30); put(8'h30); put(8'h30); put(8'h0D);
        chk("t3_no_load", 32'({bus.ld_time, bus.ld_alarm}), 32'd0);
        chk("t3_digits",  32'(digs()), 32'h0324);
        idle(2);

        // Inter-byte timeout
        put(8'h6C); put(8'h31); put(8'h32);
        idle(T - 1);
        chk("t4_busy_before", 32'(bus.busy), 32'd1);
        chk("t4_err_before",  32'(bus.cmd_err), 32'd0);
        idle(1);
        chk("t4_err",  32'(bus.cmd_err), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        idle(3);

        // Restart by new command letter
        put(8'h6C); put(8'h31); put(8'h4C);
        chk("t5_err", 32'(bus.cmd_err), 32'd1);
        put(8'h30); put(8'h30); put(8'h30); put(8'h31); put(8'h0D);
        chk("t5_ld_alarm", 32'(bus.ld_alarm), 32'd1);
        chk("t5_digits",   32'(digs()), 32'h0001);
        idle(2);

        // Reset in mid-command
        put(8'h4C); put(8'h31); put(8'h32);
        rst_n = 1'b0;
        #1;
        chk("t6_busy",   32'(bus.busy), 32'd0);
        chk("t6_digits", 32'(digs()), 32'h0000);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        put(8'h0D);
        chk("t6_no_pulse", 32'({bus.ld_time, bus.ld_alarm, bus.cmd_err}), 32'd0);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                put_gap($urandom_range(0, 1) ? 8'h6C : 8'h4C);
                put_gap(8'(8'h30 + $urandom_range(0, 5)));
                put_gap(8'(8'h30 + $urandom_range(0, 9)));
                put_gap(8'(8'h30 + $urandom_range(0, 5)));
                put_gap(8'(8'h30 + $urandom_range(0, 9)));
                put_gap(8'h0D);
            end else begin
                put_gap(rand_byte());
            end
            if (n == 200) begin
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        end
        idle(T + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
